// File: rtl/maze_pellet_eraser.sv
// Pellet eraser: probes a pellet's centre pixel through the shared read port and clears the square if a pellet is found.
// Optional score counter is built only when PELLET_SCORE_EN is defined; otherwise score is tied to 0.
module maze_pellet_eraser #(
  parameter int         ADDR_W      = 16,
  parameter int         PELLET_SZ   = 4,
  parameter logic [1:0] PELLET_CODE = 2'b10,
  parameter logic [1:0] CLEAR_CODE  = 2'b00,
  parameter int         SCORE_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               req,
  input  logic [7:0]         req_x,
  input  logic [7:0]         req_y,
  output logic               busy,
  output logic               rd_req,
  input  logic               rd_gnt,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [1:0]         data_Out,
  output logic [ADDR_W-1:0]  write_address,
  output logic [1:0]         data_In,
  output logic               we,
  output logic               done,
  output logic               ate,
  output logic [SCORE_W-1:0] score
);

  localparam int              LOG_SZ   = $clog2(PELLET_SZ);
  localparam int              IDX_W    = 2 * LOG_SZ;
  localparam logic [7:0]      HALF     = 8'(PELLET_SZ / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PELLET_SZ * PELLET_SZ - 1);

  typedef enum logic [2:0] {IDLE, PROBE, WAIT, CLEAR, DONE} state_t;

  state_t           state;
  logic [7:0]       x;
  logic [7:0]       y;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nx;
  logic [7:0]       row_nx;
  logic [7:0]       col_nx;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] py, input logic [7:0] px);
    return ADDR_W'({py, px});
  endfunction

  // Row-major walk: upper index bits select the row, lower bits the column.
  always_comb begin
    idx_nx = idx + 1'b1;
    row_nx = 8'(idx_nx[IDX_W-1:LOG_SZ]);
    col_nx = 8'(idx_nx[LOG_SZ-1:0]);
  end

  assign data_In = CLEAR_CODE;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      idx           <= '0;
      busy          <= 1'b0;
      rd_req        <= 1'b0;
      read_address  <= '0;
      write_address <= '0;
      we            <= 1'b0;
      done          <= 1'b0;
      ate           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            x            <= req_x;
            y            <= req_y;
            busy         <= 1'b1;
            rd_req       <= 1'b1;
            read_address <= pix_addr(req_y + HALF, req_x + HALF);
            state        <= PROBE;
          end
        end
        PROBE: begin
          if (rd_gnt) begin
            rd_req <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (data_Out == PELLET_CODE) begin
            idx           <= '0;
            we            <= 1'b1;
            write_address <= pix_addr(y, x);
            state         <= CLEAR;
          end else begin
            done  <= 1'b1;
            ate   <= 1'b0;
            state <= DONE;
          end
        end
        CLEAR: begin
          if (idx == LAST_IDX) begin
            we    <= 1'b0;
            done  <= 1'b1;
            ate   <= 1'b1;
            state <= DONE;
          end else begin
            idx           <= idx_nx;
            write_address <= pix_addr(y + row_nx, x + col_nx);
          end
        end
        DONE: begin
          done  <= 1'b0;
          ate   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PELLET_SCORE_EN
  // Counts on the edge that enters DONE with ate=1, so score is current while done is high.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      score <= '0;
    end else if (state == CLEAR && idx == LAST_IDX && score != '1) begin
      score <= score + 1'b1;
    end
  end
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_maze_pellet_eraser.sv
// Bench for maze_pellet_eraser: behavioural frame RAM, directed spec scenarios, then randomized requests vs. a pixel-set model.
module tb_maze_pellet_eraser;

  localparam int SZ = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req;
  logic [7:0]  req_x;
  logic [7:0]  req_y;
  logic        busy;
  logic        rd_req;
  logic        rd_gnt;
  logic [15:0] read_address;
  logic [1:0]  data_Out;
  logic [15:0] write_address;
  logic [1:0]  data_In;
  logic        we;
  logic        done;
  logic        ate;
  logic [15:0] score;

  logic [1:0]  mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [1:0]  poke_val = '0;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int score_exp = 0;

  maze_pellet_eraser dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_x(req_x), .req_y(req_y),
    .busy(busy), .rd_req(rd_req), .rd_gnt(rd_gnt), .read_address(read_address),
    .data_Out(data_Out), .write_address(write_address), .data_In(data_In),
    .we(we), .done(done), .ate(ate), .score(score)
  );

  always #5 Clk = ~Clk;

  // Frame RAM: registered read on granted edges, writes from the DUT or from bench pokes.
  always @(posedge Clk) begin
    if (rd_gnt) data_Out <= mem[read_address];
    if (we) mem[write_address] <= data_In;
    if (poke_en) mem[poke_addr] <= poke_val;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [1:0] v);
    @(negedge Clk);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    @(negedge Clk);
    poke_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"}, 64'({busy, rd_req, read_address, write_address, we, data_In, done, ate}), 64'd0);
    check({tag, "_score"}, 64'(score), 64'd0);
  endtask

  function automatic void bump_score();
`ifdef PELLET_SCORE_EN
    if (score_exp != 16'hFFFF) score_exp++;
`endif
  endfunction

  // One request: model predicts pellet/no-pellet, the write order and the latency, then the bench watches the DUT.
  task automatic run_req(input logic [7:0] x, input logic [7:0] y, input int gnt_low, input bit pulse,
                         output logic [15:0] probe, output logic [15:0] first_wr, output logic [15:0] last_wr);
    logic [15:0] centre;
    logic [1:0]  centre_val;
    bit          pellet;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          lat, rd_cycles, done_k;
    bit          ra_ok, excl_ok, busy_ok, seq_ok, clr_ok;
    logic        ate_v;
    centre     = {8'(y + SZ / 2), 8'(x + SZ / 2)};
    centre_val = mem[centre];
    pellet     = (centre_val === 2'b10);
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++)
        if (pellet) exp_q.push_back({8'(y + r), 8'(x + c)});
    lat = 2 + gnt_low + (pellet ? SZ * SZ : 0);
    rd_cycles = 0; done_k = -1; ate_v = 1'b0; probe = '0;
    ra_ok = 1; excl_ok = 1; busy_ok = 1;
    check("idle_before_req", 64'(busy), 64'd0);
    @(negedge Clk);
    req = 1'b1; req_x = x; req_y = y; rd_gnt = (gnt_low == 0);
    for (int k = 0; k < lat + 40 && done_k < 0; k++) begin
      @(negedge Clk);
      if (k == 0) begin
        probe = read_address;
        req_x = 8'($urandom);
        req_y = 8'($urandom);
      end
      req = pulse && (k == gnt_low + 4);
      if (rd_req) begin
        rd_cycles++;
        if (read_address !== centre) ra_ok = 0;
      end
      if (we) got_q.push_back(write_address);
      if (we && rd_req) excl_ok = 0;
      if (busy !== 1'b1) busy_ok = 0;
      rd_gnt = (k >= gnt_low);
      if (done === 1'b1) begin
        done_k = k;
        ate_v  = ate;
      end
    end
    req = 1'b0;
    if (pellet) bump_score();
    check("done_latency", 64'(done_k), 64'(lat));
    check("ate_value", 64'(ate_v), 64'(pellet));
    check("rd_req_cycles", 64'(rd_cycles), 64'(gnt_low + 1));
    check("read_addr_stable", 64'(ra_ok), 64'd1);
    check("we_rd_exclusive", 64'(excl_ok), 64'd1);
    check("busy_while_active", 64'(busy_ok), 64'd1);
    check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
    seq_ok = 1; clr_ok = 1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) seq_ok = 0;
    foreach (exp_q[i]) if (mem[exp_q[i]] !== 2'b00) clr_ok = 0;
    if (!pellet && mem[centre] !== centre_val) clr_ok = 0;
    check("write_sequence", 64'(seq_ok), 64'd1);
    check("ram_contents", 64'(clr_ok), 64'd1);
    first_wr = (got_q.size() > 0) ? got_q[0] : 16'h0;
    last_wr  = (got_q.size() > 0) ? got_q[got_q.size() - 1] : 16'h0;
    @(negedge Clk);
    check("idle_after_done", 64'({busy, done, rd_req, we}), 64'd0);
    check("score", 64'(score), 64'(score_exp));
  endtask

  initial begin
    logic [15:0] probe, first_wr, last_wr;
    int          nw, left;
    logic [7:0]  rx, ry;
    logic [1:0]  v;

    Reset = 1'b1; req = 1'b0; req_x = '0; req_y = '0; rd_gnt = 1'b0;
    #12;
    check_reset_outputs("reset_initial");
    @(negedge Clk);
    Reset = 1'b0;

    // Pellet at (8,16): probe 0x120A, 16 row-major writes 0x1008..0x130B.
    poke(16'h120A, 2'b10);
    run_req(8'd8, 8'd16, 0, 0, probe, first_wr, last_wr);
    check("probe_addr_8_16", 64'(probe), 64'h120A);
    check("first_wr_8_16", 64'(first_wr), 64'h1008);
    check("last_wr_8_16", 64'(last_wr), 64'h130B);

    // Reset while idle with a non-zero score.
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check_reset_outputs("reset_mid_idle");
    score_exp = 0;
    @(negedge Clk);
    Reset = 1'b0;

    // Same request, centre holds a non-pellet value.
    poke(16'h120A, 2'b01);
    run_req(8'd8, 8'd16, 0, 0, probe, first_wr, last_wr);
    check("probe_addr_nopellet", 64'(probe), 64'h120A);

    // Grant held low for 5 cycles in PROBE.
    poke({8'd52, 8'd102}, 2'b10);
    run_req(8'd100, 8'd50, 5, 0, probe, first_wr, last_wr);

    // Wrap in both x and y.
    poke(16'h0100, 2'b10);
    run_req(8'd254, 8'd255, 0, 0, probe, first_wr, last_wr);
    check("probe_addr_wrap", 64'(probe), 64'h0100);
    check("first_wr_wrap", 64'(first_wr), 64'hFFFE);
    check("last_wr_wrap", 64'(last_wr), 64'h0201);

    // req pulsed during CLEAR is ignored.
    poke({8'd42, 8'd32}, 2'b10);
    run_req(8'd30, 8'd40, 1, 1, probe, first_wr, last_wr);

    // Reset after the 5th write leaves 11 pellet pixels untouched.
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++)
        poke({8'(70 + r), 8'(60 + c)}, 2'b10);
    @(negedge Clk);
    req = 1'b1; req_x = 8'd60; req_y = 8'd70; rd_gnt = 1'b1;
    @(negedge Clk);
    req = 1'b0;
    nw = 0;
    for (int k = 0; k < 60 && nw < 5; k++) begin
      if (we) nw++;
      if (nw < 5) @(negedge Clk);
    end
    check("writes_before_reset", 64'(nw), 64'd5);
    @(negedge Clk);
    Reset = 1'b1;
    #1 check_reset_outputs("reset_mid_clear");
    score_exp = 0;
    left = 0;
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++)
        if (mem[{8'(70 + r), 8'(60 + c)}] === 2'b10) left++;
    check("pixels_left", 64'(left), 64'd11);
    @(negedge Clk);
    Reset = 1'b0;

    // Randomized requests against the model.
    for (int i = 0; i < 20; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      if ($urandom_range(0, 1) == 1) v = 2'b10;
      else begin
        v = 2'($urandom_range(0, 2));
        if (v == 2'b10) v = 2'b11;
      end
      poke({8'(ry + SZ / 2), 8'(rx + SZ / 2)}, v);
      run_req(rx, ry, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), probe, first_wr, last_wr);
      check("probe_addr_rand", 64'(probe), 64'({8'(ry + SZ / 2), 8'(rx + SZ / 2)}));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
